// File: rtl/syncfifo_flex.sv
// syncfifo_flex -- parametrised single-clock FIFO.
//
// Read modes: FWFT=0 registered read (dout one cycle after an accepted
// rden), FWFT=1 first-word-fall-through (head word shown combinationally,
// rden pops it). Adds almost-full/almost-empty flags, an occupancy count,
// sticky overflow/underflow flags and a synchronous flush.
//
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   clr              synchronous flush: empties FIFO, clears ovf/udf
//   wren, din        write request and data
//   rden             read request (FWFT: pop the word on dout)
//   dout, dvalid     read data and its valid flag
//   full, empty      level == DEPTH / level == 0
//   afull, aempty    level >= AFULL_TH / level <= AEMPTY_TH
//   level            occupancy, 0..DEPTH
//   ovf, udf         sticky: write while full / read while empty
module syncfifo_flex #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              wren,
  input  logic [DWIDTH-1:0] din,
  input  logic              rden,
  output logic [DWIDTH-1:0] dout,
  output logic              dvalid,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic [AWIDTH:0]   level,
  output logic              ovf,
  output logic              udf
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_L  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AFULL_L  = (AWIDTH+1)'(AFULL_TH);
  localparam logic [AWIDTH:0] AEMPTY_L = (AWIDTH+1)'(AEMPTY_TH);

  // Reject illegal configurations at elaboration.
  if (AWIDTH < 1) begin : g_bad_awidth
    $error("syncfifo_flex: AWIDTH must be >= 1");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("syncfifo_flex: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH-1) begin : g_bad_aempty
    $error("syncfifo_flex: AEMPTY_TH must be in 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("syncfifo_flex: FWFT must be 0 or 1");
  end

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wptr, rptr;
  logic [AWIDTH:0]   level_q, level_next;
  logic              wr_acc, rd_acc;
  logic              ovf_q, udf_q;

  // Status flags come straight off the registered level, so they only
  // change once per edge and never see the request inputs.
  assign full   = (level_q == DEPTH_L);
  assign empty  = (level_q == '0);
  assign afull  = (level_q >= AFULL_L);
  assign aempty = (level_q <= AEMPTY_L);
  assign level  = level_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

  // Flush wins over both requests. Full/empty gating means a full FIFO
  // with wren&rden only reads and an empty one only writes.
  assign wr_acc = wren & ~full  & ~clr;
  assign rd_acc = rden & ~empty & ~clr;

  always_comb begin
    level_next = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_next = level_q + 1'b1;
      2'b01:   level_next = level_q - 1'b1;
      default: level_next = level_q;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= din;
  end

  // Pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else if (clr) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      level_q <= level_next;
    end
  end

  // Sticky error flags; requests are ignored while clr is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wren & full)  ovf_q <= 1'b1;
      if (rden & empty) udf_q <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is visible as soon as the level says non-empty; a
    // zero is forced while empty so stale storage never leaks out.
    assign dout   = empty ? '0 : mem[rptr];
    assign dvalid = ~empty;
  end else begin : g_std
    logic [DWIDTH-1:0] dout_q;
    logic              dvalid_q;

    // dout holds its last word across idle cycles and flushes; only
    // dvalid pulses for the cycle after an accepted read.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        dout_q   <= '0;
        dvalid_q <= 1'b0;
      end else if (rd_acc) begin
        dout_q   <= mem[rptr];
        dvalid_q <= 1'b1;
      end else begin
        dvalid_q <= 1'b0;
      end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
  end

endmodule

// File: tb/tb_syncfifo_flex.sv
module tb_syncfifo_flex;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clr = 1'b0, wren = 1'b0, rden = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] s_dout, f_dout;
  logic [4:0] s_level, f_level;
  logic s_dvalid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic f_dvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of stored words plus sticky flags and the
  // registered-read output of the standard-mode instance.
  logic [7:0] q[$];
  bit         m_ovf, m_udf, m_dv;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  syncfifo_flex #(.DWIDTH(8), .AWIDTH(4), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(2)) u_std (
    .clk(clk), .rstn(rstn), .clr(clr), .wren(wren), .din(din), .rden(rden),
    .dout(s_dout), .dvalid(s_dvalid), .full(s_full), .empty(s_empty),
    .afull(s_afull), .aempty(s_aempty), .level(s_level), .ovf(s_ovf), .udf(s_udf));

  syncfifo_flex #(.DWIDTH(8), .AWIDTH(4), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(2)) u_fw (
    .clk(clk), .rstn(rstn), .clr(clr), .wren(wren), .din(din), .rden(rden),
    .dout(f_dout), .dvalid(f_dvalid), .full(f_full), .empty(f_empty),
    .afull(f_afull), .aempty(f_aempty), .level(f_level), .ovf(f_ovf), .udf(f_udf));

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_dv = 0; m_dout = 8'h00;
  endtask

  // Drive one cycle of requests, let the edge happen, advance the model,
  // and return #1 after the edge with the requests deasserted.
  task automatic step(input bit c, input bit w, input bit r, input logic [7:0] d);
    bit was_full, was_empty;
    clr = c; wren = w; rden = r; din = d;
    @(posedge clk);
    was_full  = (q.size() == 16);
    was_empty = (q.size() == 0);
    if (c) begin
      q.delete(); m_ovf = 0; m_udf = 0; m_dv = 0;
    end else begin
      if (w && was_full)  m_ovf = 1;
      if (r && was_empty) m_udf = 1;
      if (r && !was_empty) begin m_dout = q.pop_front(); m_dv = 1; end
      else m_dv = 0;
      if (w && !was_full) q.push_back(d);
    end
    #1;
    clr = 0; wren = 0; rden = 0;
  endtask

  task automatic test_reset();
    rstn = 0; clr = 0; wren = 0; rden = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_dout, s_dvalid, s_full, s_empty, s_afull, s_aempty, s_level, s_ovf, s_udf}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_std: got %h expected %h",
        {s_dout, s_dvalid, s_full, s_empty, s_afull, s_aempty, s_level, s_ovf, s_udf},
        {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0});
    end
    checks++;
    if ({f_dout, f_dvalid, f_full, f_empty, f_afull, f_aempty, f_level, f_ovf, f_udf}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_fwft: got %h expected %h",
        {f_dout, f_dvalid, f_full, f_empty, f_afull, f_aempty, f_level, f_ovf, f_udf},
        {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0});
    end
    rstn = 1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'(i));
      checks++;
      if ({s_level, s_full, s_afull, s_aempty, s_ovf}
          !== {5'(i+1), 1'(i == 15), 1'(i >= 11), 1'(i <= 1), 1'b0}) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got lvl/full/afull/aempty/ovf=%b expected %b", i,
          {s_level, s_full, s_afull, s_aempty, s_ovf},
          {5'(i+1), 1'(i == 15), 1'(i >= 11), 1'(i <= 1), 1'b0});
      end
      checks++;
      if ({f_dout, f_dvalid, f_level} !== {8'h00, 1'b1, 5'(i+1)}) begin
        errors++;
        $display("FAIL fill_fwft_head[%0d]: got %h expected %h", i,
          {f_dout, f_dvalid, f_level}, {8'h00, 1'b1, 5'(i+1)});
      end
    end
    step(0, 1, 0, 8'hFF);
    checks++;
    if ({s_level, s_full, s_ovf, f_ovf} !== {5'd16, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL fill_overflow: got lvl/full/ovf/fovf=%b expected %b",
        {s_level, s_full, s_ovf, f_ovf}, {5'd16, 1'b1, 1'b1, 1'b1});
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (f_dout !== 8'(i)) begin
        errors++;
        $display("FAIL drain_fwft_head[%0d]: got %h expected %h", i, f_dout, 8'(i));
      end
      step(0, 0, 1, 8'h00);
      checks++;
      if ({s_dout, s_dvalid} !== {8'(i), 1'b1}) begin
        errors++;
        $display("FAIL drain_std_data[%0d]: got dout=%h dvalid=%b expected %h 1",
          i, s_dout, s_dvalid, 8'(i));
      end
    end
    checks++;
    if ({s_empty, s_level, f_dout, f_dvalid, s_udf} !== {1'b1, 5'd0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL drain_empty: got %h expected %h",
        {s_empty, s_level, f_dout, f_dvalid, s_udf}, {1'b1, 5'd0, 8'h00, 1'b0, 1'b0});
    end
    step(0, 0, 1, 8'h00);
    checks++;
    if ({s_udf, f_udf, s_dvalid, s_level, s_dout} !== {1'b1, 1'b1, 1'b0, 5'd0, 8'h0F}) begin
      errors++;
      $display("FAIL drain_underflow: got udf/fudf/dvalid/lvl/dout=%h expected %h",
        {s_udf, f_udf, s_dvalid, s_level, s_dout}, {1'b1, 1'b1, 1'b0, 5'd0, 8'h0F});
    end
  endtask

  task automatic test_wrap();
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'h40 + i));
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 1, 8'(8'h44 + k));
      checks++;
      if ({s_level, s_dout, s_dvalid, s_ovf, s_udf, f_dout}
          !== {5'd4, 8'(8'h40 + k), 1'b1, 1'b0, 1'b0, 8'(8'h41 + k)}) begin
        errors++;
        $display("FAIL wrap[%0d]: got lvl/dout/dv/ovf/udf/fdout=%h expected %h", k,
          {s_level, s_dout, s_dvalid, s_ovf, s_udf, f_dout},
          {5'd4, 8'(8'h40 + k), 1'b1, 1'b0, 1'b0, 8'(8'h41 + k)});
      end
    end
  endtask

  task automatic test_simultaneous();
    step(1, 0, 0, 8'h00);
    step(0, 1, 1, 8'h77);
    checks++;
    if ({s_level, s_udf, s_ovf, s_dvalid, f_dout} !== {5'd1, 1'b1, 1'b0, 1'b0, 8'h77}) begin
      errors++;
      $display("FAIL simul_empty: got lvl/udf/ovf/dv/fdout=%h expected %h",
        {s_level, s_udf, s_ovf, s_dvalid, f_dout}, {5'd1, 1'b1, 1'b0, 1'b0, 8'h77});
    end
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'h10 + i));
    step(0, 1, 1, 8'hEE);
    checks++;
    if ({s_level, s_ovf, s_udf, s_dout, s_dvalid, f_dout}
        !== {5'd15, 1'b1, 1'b0, 8'h10, 1'b1, 8'h11}) begin
      errors++;
      $display("FAIL simul_full: got lvl/ovf/udf/dout/dv/fdout=%h expected %h",
        {s_level, s_ovf, s_udf, s_dout, s_dvalid, f_dout},
        {5'd15, 1'b1, 1'b0, 8'h10, 1'b1, 8'h11});
    end
  endtask

  task automatic test_clr();
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'h20 + i));
    step(0, 1, 0, 8'hFF);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 8'h00);
    checks++;
    if ({s_level, s_ovf, s_dout} !== {5'd7, 1'b1, 8'h28}) begin
      errors++;
      $display("FAIL clr_setup: got lvl/ovf/dout=%h expected %h",
        {s_level, s_ovf, s_dout}, {5'd7, 1'b1, 8'h28});
    end
    step(1, 1, 0, 8'h99);
    checks++;
    if ({s_level, s_empty, s_full, s_aempty, s_afull, s_ovf, s_udf, s_dvalid, s_dout}
        !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h28}) begin
      errors++;
      $display("FAIL clr_std: got %h expected %h",
        {s_level, s_empty, s_full, s_aempty, s_afull, s_ovf, s_udf, s_dvalid, s_dout},
        {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h28});
    end
    checks++;
    if ({f_level, f_dout, f_dvalid, f_ovf} !== {5'd0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clr_fwft: got %h expected %h",
        {f_level, f_dout, f_dvalid, f_ovf}, {5'd0, 8'h00, 1'b0, 1'b0});
    end
    step(0, 0, 0, 8'h00);
    checks++;
    if ({s_level, f_dvalid} !== {5'd0, 1'b0}) begin
      errors++;
      $display("FAIL clr_nothing_written: got lvl=%0d fdvalid=%b expected 0 0", s_level, f_dvalid);
    end
  endtask

  task automatic test_fwft_latency();
    step(1, 0, 0, 8'h00);
    checks++;
    if ({f_dout, f_dvalid} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL fwft_idle: got dout=%h dvalid=%b expected 00 0", f_dout, f_dvalid);
    end
    step(0, 1, 0, 8'hA5);
    checks++;
    if ({f_dout, f_dvalid} !== {8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL fwft_visible: got dout=%h dvalid=%b expected a5 1", f_dout, f_dvalid);
    end
    step(0, 0, 1, 8'h00);
    checks++;
    if ({f_dout, f_dvalid, f_empty, f_udf} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fwft_pop: got dout=%h dvalid=%b empty=%b udf=%b expected 00 0 1 0",
        f_dout, f_dvalid, f_empty, f_udf);
    end
  endtask

  task automatic test_random();
    int wp;
    logic [17:0] exp_s, got_s;
    logic [14:0] exp_f, got_f;
    step(1, 0, 0, 8'h00);
    for (int n = 0; n < 400; n++) begin
      wp = ((n / 40) % 2 == 0) ? 75 : 30;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < wp,
           $urandom_range(0, 99) < 50, 8'($urandom));
      exp_s = {m_dout, m_dv, 1'(q.size() == 16), 1'(q.size() == 0),
               1'(q.size() >= 12), 1'(q.size() <= 2), 5'(q.size()), m_ovf, m_udf} >> 0;
      got_s = {s_dout, s_dvalid, s_full, s_empty, s_afull, s_aempty, s_level, s_ovf, s_udf} >> 0;
      checks++;
      if (got_s !== exp_s) begin
        errors++;
        $display("FAIL random_std[%0d]: got %h expected %h", n, got_s, exp_s);
      end
      exp_f = {(q.size() != 0) ? q[0] : 8'h00, 1'(q.size() != 0), 5'(q.size()), m_ovf};
      got_f = {f_dout, f_dvalid, f_level, f_ovf};
      checks++;
      if (got_f !== exp_f) begin
        errors++;
        $display("FAIL random_fwft[%0d]: got %h expected %h", n, got_f, exp_f);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 8'(8'h60 + i));
    wren = 1; rden = 1; din = 8'h6F;
    #3;
    rstn = 0;
    #1;
    checks++;
    if ({s_dout, s_dvalid, s_full, s_empty, s_afull, s_aempty, s_level, s_ovf, s_udf}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_std: got %h expected %h",
        {s_dout, s_dvalid, s_full, s_empty, s_afull, s_aempty, s_level, s_ovf, s_udf},
        {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0});
    end
    checks++;
    if ({f_dout, f_dvalid, f_level, f_udf} !== {8'h00, 1'b0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_fwft: got %h expected %h",
        {f_dout, f_dvalid, f_level, f_udf}, {8'h00, 1'b0, 5'd0, 1'b0});
    end
    wren = 0; rden = 0;
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_clr();
    test_fwft_latency();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/syncfifo_flex.md
Name: syncfifo_flex

Overview:
Parametrised single-clock FIFO and the next generation of the team's basic sync FIFO. It adds:
- selectable read mode: standard registered read, or first-word-fall-through (FWFT);
- programmable almost-full and almost-empty flags;
- an occupancy output;
- sticky overflow and underflow flags;
- a synchronous flush.

It sits between producer and consumer datapath stages in the same clock domain, for rate smoothing and back-pressure.

Parameters:
DWIDTH, 8, data word width in bits.
AWIDTH, 4, address width; DEPTH = 2**AWIDTH entries.
FWFT, 0, read mode: 0 = standard (data one cycle after rden), 1 = first-word-fall-through.
AFULL_TH, 12, afull asserts when level >= AFULL_TH; legal range 1..DEPTH.
AEMPTY_TH, 2, aempty asserts when level <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
clk     input   1          clock; all logic on the rising edge.
rstn    input   1          asynchronous active-low reset.
clr     input   1          synchronous flush; empties the FIFO and clears the sticky flags.
wren    input   1          write request.
din     input   DWIDTH     write data.
rden    input   1          read request (in FWFT mode: pop).
dout    output  DWIDTH     read data.
dvalid  output  1          dout holds valid data.
full    output  1          level == DEPTH.
empty   output  1          level == 0.
afull   output  1          level >= AFULL_TH.
aempty  output  1          level <= AEMPTY_TH.
level   output  AWIDTH+1   current occupancy, 0..DEPTH.
ovf     output  1          sticky: a write was attempted while full.
udf     output  1          sticky: a read was attempted while empty.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values: wptr, rptr, level = 0; empty = 1; full = 0; afull = 0; aempty = 1; ovf = 0; udf = 0; dout = 0; dvalid = 0. The storage array is not reset.
- Acceptance:
  - wr_acc = wren & ~full & ~clr; rd_acc = rden & ~empty & ~clr.
  - full and empty are evaluated on the registered level before the edge.
- Occupancy and pointers:
  - level_next = level + wr_acc - rd_acc.
  - Simultaneous accepted read and write leave level unchanged; both pointers advance.
  - Pointers are AWIDTH bits and wrap modulo DEPTH with no special handling.
- Boundary cases:
  - Empty with wren & rden: the write is accepted, the read is rejected, udf sets, level becomes 1.
  - Full with wren & rden: the read is accepted, the write is rejected, ovf sets, level becomes DEPTH-1.
- Flag derivation:
  - full, empty, afull, aempty are derived from the registered level only: glitch-free, valid in the cycle after the causing edge.
  - ovf sets on wren & full & ~clr; udf sets on rden & empty & ~clr. Both hold until clr or reset.
- Written data is stored at mem[wptr] on the edge where wr_acc = 1.
- Standard mode (FWFT=0):
  - On an rd_acc edge, dout <= mem[rptr] and dvalid <= 1.
  - Otherwise dvalid <= 0 and dout holds its last value.
  - Read latency is 1 cycle from the rden edge.
- FWFT mode (FWFT=1):
  - dout = mem[rptr] when ~empty, else 0 (combinational from registered state); dvalid = ~empty.
  - Write-to-visible latency: a word written into an empty FIFO appears on dout the cycle after the write edge.
  - rden consumes the current dout word; the next word is visible the following cycle.
- clr:
  - Takes priority over wren and rden in the same cycle; both are ignored, and no ovf/udf update.
  - Next cycle: pointers = 0, level = 0, flags at reset values, dvalid = 0.
  - FWFT=0: dout holds. FWFT=1: dout = 0.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Stored data is discarded logically.
- Illegal parameters (thresholds out of range, AWIDTH < 1) cause an elaboration-time error.

Test Plan:
- Defaults, FWFT=0, write 16 words 0x00..0x0F:
  - level counts to 16; full = 1 after the 16th edge;
  - afull rises after the 12th write; aempty falls after the 3rd write;
  - a 17th wren sets ovf and level stays 16.
- Drain the above with 16 reads:
  - dout = 0x00..0x0F in order, each dvalid 1 cycle after its rden;
  - empty = 1 at the end; a further rden sets udf and dvalid stays 0.
- Wrap-around: 20 write/read pairs on a continuously occupied FIFO:
  - level stays constant; data is in order across the pointer wrap; no ovf/udf.
- Simultaneous wren & rden:
  - on empty: level = 1, udf = 1;
  - on full: level = 15, ovf = 1, the oldest word is read out.
- FWFT=1, write 0xA5 into an empty FIFO:
  - next cycle dout = 0xA5, dvalid = 1;
  - rden with no further writes: empty = 1, dout = 0 next cycle.
- clr with 7 words stored and ovf = 1, wren = 1 in the same cycle:
  - next cycle level = 0, empty = 1, ovf = 0, nothing written.
  - rstn pulled low mid-burst: all outputs at reset values without waiting for a clock edge.
